// File: rtl/qa_drv_hc_write_tracker_pkg.sv
// Shared types and default constants for the CCI write tracker.
package qa_drv_hc_write_tracker_pkg;

    localparam int DEF_MAX_OUTSTANDING = 64;
    localparam int DEF_THROTTLE_THRESH = 56;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } t_wr_trk_state;

endpackage

// File: rtl/qa_drv_hc_sat_updown_counter.sv
// Saturating up/down counter: one increment and two decrement strobes per cycle.
// The count clamps to 0 below and MAX_COUNT above; the flags report when the
// raw next value fell outside that range in the current cycle.
module qa_drv_hc_sat_updown_counter #(
    parameter int MAX_COUNT = 64,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec0_i,
    input  logic             dec1_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] next_count_o,
    output logic             underflow_o,
    output logic             overflow_o
);

    // Two extra bits: one for the +1 headroom, one for the sign of -2.
    localparam logic signed [CNT_W+1:0] MAX_S = signed'((CNT_W + 2)'(MAX_COUNT));
    localparam logic [CNT_W-1:0]        MAX_C = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic signed [CNT_W+1:0] sum_w;
    logic                    underflow_w;
    logic                    overflow_w;

    // Signed next-count arithmetic followed by clamping into [0, MAX_COUNT].
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        count_d     = count_q;
        sum_w       = signed'({2'b00, count_q})
                    + signed'({{(CNT_W + 1){1'b0}}, inc_i})
                    - signed'({{(CNT_W + 1){1'b0}}, dec0_i})
                    - signed'({{(CNT_W + 1){1'b0}}, dec1_i});
        underflow_w = sum_w[CNT_W+1];
        overflow_w  = !underflow_w && (sum_w > MAX_S);
        if (underflow_w) begin
            count_d = '0;
        end else if (overflow_w) begin
            count_d = MAX_C;
        end else begin
            count_d = sum_w[CNT_W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign next_count_o = count_d;
    assign underflow_o  = underflow_w;
    assign overflow_o   = overflow_w;

endmodule

// File: rtl/qa_drv_hc_write_tracker.sv
// Tracks CCI writes in flight (issued on tx1, acknowledged on rx0/rx1),
// throttles the write arbiter near the limit and implements a write fence:
// fence_req drains all outstanding writes, then fence_ack pulses once.
// Optional drain watchdog: define QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN.
module qa_drv_hc_write_tracker
    import qa_drv_hc_write_tracker_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int THROTTLE_THRESH = DEF_THROTTLE_THRESH, // legal 1..MAX_OUTSTANDING
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx1_wrvalid,
    input  logic             rx0_wrrsp,
    input  logic             rx1_wrrsp,
    input  logic             fence_req,
    output logic             fence_ack,
    output logic             throttle,
    output logic [CNT_W-1:0] outstanding,
    output logic             idle,
    output logic             err_underflow,
    output logic             err_overflow
`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
   ,output logic             err_timeout
`endif
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THROTTLE_THRESH);

    // Reject illegal parameter combinations at elaboration.
    if (THROTTLE_THRESH < 1 || THROTTLE_THRESH > MAX_OUTSTANDING || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("qa_drv_hc_write_tracker: illegal THROTTLE_THRESH or TIMEOUT_CYCLES");
    end

    t_wr_trk_state    state_q;
    t_wr_trk_state    state_d;
    logic [CNT_W-1:0] count_w;
    logic [CNT_W-1:0] next_count_w;
    logic             underflow_w;
    logic             overflow_w;
    logic             drain_hold_w;
    logic             throttle_q;
    logic             idle_q;
    logic             err_underflow_q;
    logic             err_overflow_q;

    qa_drv_hc_sat_updown_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_W     (CNT_W)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (tx1_wrvalid),
        .dec0_i       (rx0_wrrsp),
        .dec1_i       (rx1_wrrsp),
        .count_o      (count_w),
        .next_count_o (next_count_w),
        .underflow_o  (underflow_w),
        .overflow_o   (overflow_w)
    );

`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
    localparam int             WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_HIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            err_timeout_q;
    logic            timeout_hit_w;

    // This cycle is the TIMEOUT_CYCLES-th consecutive cycle spent in DRAIN.
    assign timeout_hit_w = (state_q == DRAIN) && (wd_q == WD_HIT);
    // After a timeout the fence is stuck in DRAIN until reset.
    assign drain_hold_w  = err_timeout_q || timeout_hit_w;

    // Drain watchdog: counts DRAIN cycles (saturating), clears outside DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_q == DRAIN) begin
                if (wd_q != WD_MAX) begin
                    wd_q <= wd_q + WD_W'(1);
                end
            end else begin
                wd_q <= '0;
            end
            err_timeout_q <= err_timeout_q || timeout_hit_w;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign drain_hold_w = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fence_req is only looked at in IDLE; DRAIN exits once
    // the registered count is zero and no write is being issued this cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fence_req) state_d = DRAIN;
            DRAIN:   if ((count_w == '0) && !tx1_wrvalid && !drain_hold_w) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: fence_ack is high for the single cycle spent in ACK.
    always_comb begin
        fence_ack = (state_q == ACK);
    end

    // Registered status outputs, derived from next count and next state;
    // error flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            throttle_q      <= 1'b0;
            idle_q          <= 1'b1;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            throttle_q      <= (next_count_w >= THRESH_C) || (state_d != IDLE);
            idle_q          <= (next_count_w == '0) && (state_d == IDLE);
            err_underflow_q <= err_underflow_q || underflow_w;
            err_overflow_q  <= err_overflow_q || overflow_w;
        end
    end

    assign throttle      = throttle_q;
    assign idle          = idle_q;
    assign outstanding   = count_w;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_qa_drv_hc_write_tracker.sv
// Self-checking bench for qa_drv_hc_write_tracker. Each driven cycle pushes
// the expected post-edge outputs (from an integer reference model) to a
// scoreboard queue; they are popped and compared one time unit after the edge.
module tb_qa_drv_hc_write_tracker;

    localparam int MAX   = 64;
    localparam int THR   = 56;
    localparam int TO    = 16;
    localparam int CNT_W = $clog2(MAX + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tx1_wrvalid = 1'b0;
    logic             rx0_wrrsp = 1'b0;
    logic             rx1_wrrsp = 1'b0;
    logic             fence_req = 1'b0;
    logic             fence_ack;
    logic             throttle;
    logic [CNT_W-1:0] outstanding;
    logic             idle;
    logic             err_underflow;
    logic             err_overflow;
`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
    logic             err_timeout;
`endif

    always #5 clk = ~clk;

    qa_drv_hc_write_tracker #(
        .MAX_OUTSTANDING (MAX),
        .THROTTLE_THRESH (THR),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx1_wrvalid   (tx1_wrvalid),
        .rx0_wrrsp     (rx0_wrrsp),
        .rx1_wrrsp     (rx1_wrrsp),
        .fence_req     (fence_req),
        .fence_ack     (fence_ack),
        .throttle      (throttle),
        .outstanding   (outstanding),
        .idle          (idle),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
       ,.err_timeout   (err_timeout)
`endif
    );

    typedef struct {
        string tag;
        int    cnt;
        bit    thr;
        bit    idl;
        bit    ack;
        bit    eu;
        bit    eo;
        bit    et;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_ack = 0;

    // Reference model state: 0 = IDLE, 1 = DRAIN, 2 = ACK.
    int m_cnt, m_state, m_wd;
    bit m_eu, m_eo, m_et;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.cnt = m_cnt;
        e.thr = (m_cnt >= THR) || (m_state != 0);
        e.idl = (m_cnt == 0) && (m_state == 0);
        e.ack = (m_state == 2);
        e.eu  = m_eu;
        e.eo  = m_eo;
        e.et  = m_et;
        sb.push_back(e);
    endtask

    task automatic compare_top();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".outstanding"}, 32'(outstanding), 32'(e.cnt));
        check({e.tag, ".throttle"}, 32'(throttle), 32'(e.thr));
        check({e.tag, ".idle"}, 32'(idle), 32'(e.idl));
        check({e.tag, ".fence_ack"}, 32'(fence_ack), 32'(e.ack));
        check({e.tag, ".err_underflow"}, 32'(err_underflow), 32'(e.eu));
        check({e.tag, ".err_overflow"}, 32'(err_overflow), 32'(e.eo));
`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
        check({e.tag, ".err_timeout"}, 32'(err_timeout), 32'(e.et));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx1_wrvalid = 1'b0;
        rx0_wrrsp = 1'b0;
        rx1_wrrsp = 1'b0;
        fence_req = 1'b0;
        m_cnt = 0; m_state = 0; m_wd = 0;
        m_eu = 0; m_eo = 0; m_et = 0;
        repeat (2) begin
            push_exp("reset");
            @(posedge clk);
            #1;
            compare_top();
        end
        reset = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model, compare after the edge.
    task automatic cycle(input bit t, input bit a, input bit b, input bit f, input string tag);
        int sum;
        int ns;
        tx1_wrvalid = t;
        rx0_wrrsp = a;
        rx1_wrrsp = b;
        fence_req = f;
        sum = m_cnt + int'(t) - int'(a) - int'(b);
        case (m_state)
            0: ns = f ? 1 : 0;
            1: begin
                ns = (m_cnt == 0 && !t) ? 2 : 1;
`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
                if (m_et || m_wd == TO - 1) ns = 1;
`endif
            end
            default: ns = 0;
        endcase
`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
        if (m_state == 1 && m_wd == TO - 1) m_et = 1;
        m_wd = (m_state == 1) ? ((m_wd < TO) ? m_wd + 1 : m_wd) : 0;
`endif
        if (sum < 0) begin
            m_eu = 1;
            m_cnt = 0;
        end else if (sum > MAX) begin
            m_eo = 1;
            m_cnt = MAX;
        end else begin
            m_cnt = sum;
        end
        m_state = ns;
        push_exp(tag);
        @(posedge clk);
        #1;
        compare_top();
        if (fence_ack === 1'b1) n_ack++;
    endtask

    initial begin
        int peak;
        int thr_low;

        do_reset();

        // Ten back-to-back writes, then ten responses on rx0.
        peak = 0;
        repeat (10) begin
            cycle(1, 0, 0, 0, "burst_wr");
            if (int'(outstanding) > peak) peak = int'(outstanding);
        end
        check("burst_peak", 32'(peak), 32'd10);
        repeat (10) cycle(0, 1, 0, 0, "burst_rsp");
        check("burst_zero", 32'(outstanding), 32'd0);
        check("burst_idle", 32'(idle), 32'd1);

        // Issue plus two responses at count 5 nets -1; issue plus one nets 0.
        repeat (5) cycle(1, 0, 0, 0, "pre5");
        cycle(1, 1, 1, 0, "tx_rx0_rx1");
        check("net_minus_one", 32'(outstanding), 32'd4);
        cycle(1, 1, 0, 0, "tx_rx0");
        check("net_zero", 32'(outstanding), 32'd4);
        repeat (2) cycle(0, 1, 1, 0, "drain_pair");

        // Throttle threshold crossing.
        repeat (55) cycle(1, 0, 0, 0, "fill");
        check("thr_below", 32'(throttle), 32'd0);
        cycle(1, 0, 0, 0, "fill56");
        check("thr_at_56_cnt", 32'(outstanding), 32'd56);
        check("thr_at_56", 32'(throttle), 32'd1);
        cycle(0, 0, 1, 0, "rsp_to_55");
        check("thr_release", 32'(throttle), 32'd0);
        repeat (55) cycle(0, 1, 0, 0, "empty");

        // Fence with 3 outstanding: one-cycle request, responses after 5 cycles.
        repeat (3) cycle(1, 0, 0, 0, "f_wr");
        n_ack = 0;
        thr_low = 0;
        cycle(0, 0, 0, 1, "f_req");
        if (throttle !== 1'b1) thr_low++;
        repeat (5) begin
            cycle(0, 0, 0, 0, "f_wait");
            if (throttle !== 1'b1) thr_low++;
        end
        repeat (3) begin
            cycle(0, 1, 0, 0, "f_rsp");
            if (throttle !== 1'b1) thr_low++;
        end
        repeat (4) cycle(0, 0, 0, 0, "f_done");
        check("fence_ack_count", 32'(n_ack), 32'd1);
        check("fence_throttle_low", 32'(thr_low), 32'd0);
        check("fence_idle", 32'(idle), 32'd1);

        // fence_req held high across ACK starts a second fence.
        n_ack = 0;
        repeat (6) cycle(0, 0, 0, 1, "fence_held");
        check("refence_acks", 32'(n_ack), 32'd2);
        cycle(0, 0, 0, 0, "fence_release");

        // Response in the first cycle after reset underflows; flag is sticky.
        do_reset();
        cycle(0, 0, 1, 0, "first_rsp");
        check("uf_cnt", 32'(outstanding), 32'd0);
        check("uf_flag", 32'(err_underflow), 32'd1);
        repeat (3) cycle(1, 0, 0, 0, "after_uf");
        check("uf_sticky", 32'(err_underflow), 32'd1);

        // 65 writes in total saturate at MAX and set the overflow flag.
        repeat (62) cycle(1, 0, 0, 0, "ovf_fill");
        check("ovf_cnt", 32'(outstanding), 32'(MAX));
        check("ovf_flag", 32'(err_overflow), 32'd1);

        // Reset in DRAIN aborts the fence without an acknowledge.
        cycle(0, 0, 0, 1, "fence_full");
        repeat (3) cycle(0, 0, 0, 0, "drain_hold");
        n_ack = 0;
        do_reset();
        repeat (3) cycle(0, 0, 0, 0, "post_abort");
        check("abort_no_ack", 32'(n_ack), 32'd0);
        check("abort_idle", 32'(idle), 32'd1);
        check("abort_errs_clear", 32'({err_underflow, err_overflow}), 32'd0);

`ifdef QA_DRV_HC_WRITE_TRACKER_TIMEOUT_EN
        // Fence with one write that is never acknowledged trips the watchdog.
        cycle(1, 0, 0, 0, "to_wr");
        n_ack = 0;
        cycle(0, 0, 0, 1, "to_fence");
        repeat (15) cycle(0, 0, 0, 0, "to_wait");
        check("to_not_yet", 32'(err_timeout), 32'd0);
        cycle(0, 0, 0, 0, "to_hit");
        check("to_flag", 32'(err_timeout), 32'd1);
        repeat (3) cycle(0, 1, 0, 0, "to_late_rsp");
        check("to_no_ack", 32'(n_ack), 32'd0);
        check("to_stuck_throttle", 32'(throttle), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
